// File: rtl/multi_chan_seq_ctrl.sv
// multi_chan_seq_ctrl: NUM_CH job sequencers (start/stop/err in; rdy/busy/endd/stop/er/req/ack/irq/irq_stat/any_irq out)
module multi_chan_seq_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int JOB_LEN = 8,
  parameter int HOLDOFF = 2,
  parameter int ERR_MAX = 3,
  parameter int ACK_LAT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] start_i,
  input  logic [NUM_CH-1:0] stop_i,
  input  logic [NUM_CH-1:0] err_i,
  input  logic [NUM_CH-1:0] irq_clr_i,
  output logic [NUM_CH-1:0] rdy_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] endd_o,
  output logic [NUM_CH-1:0] stop_o,
  output logic [NUM_CH-1:0] er_o,
  output logic [NUM_CH-1:0] req_o,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic [NUM_CH-1:0] irq_stat_o,
  output logic              any_irq_o
);
  typedef enum logic [2:0] {IDLE, RUN, DONE, STOP, ERR, HOLD} state_t;
  localparam int MAXV = (JOB_LEN > HOLDOFF) ? ((JOB_LEN > ERR_MAX) ? JOB_LEN : ERR_MAX)
                                            : ((HOLDOFF > ERR_MAX) ? HOLDOFF : ERR_MAX);
  localparam int CW = $clog2(MAXV + 1);
  logic [NUM_CH-1:0] stat_d_v;
  logic any_irq_d, any_irq_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [ACK_LAT-1:0] sr_q, sr_d;
    logic [ACK_LAT:0] sr_x;
    logic irq_q, irq_d, stat_q, stat_d;
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      case (st_q)
        IDLE: if (start_i[c]) begin
          st_d = RUN;
          cnt_d = CW'(JOB_LEN - 1);
        end
        RUN: if (err_i[c]) begin
          st_d = ERR;
          cnt_d = CW'(1);
        end else if (stop_i[c]) st_d = STOP;
        else if (cnt_q == '0) st_d = DONE;
        else cnt_d = cnt_q - CW'(1);
        DONE, STOP: begin
          st_d = HOLD;
          cnt_d = CW'(HOLDOFF - 1);
        end
        ERR: if (err_i[c] && cnt_q < CW'(ERR_MAX)) cnt_d = cnt_q + CW'(1);
        else begin
          st_d = HOLD;
          cnt_d = CW'(HOLDOFF - 1);
        end
        HOLD: if (cnt_q == '0) st_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
        default: st_d = IDLE;
      endcase
    end
    assign irq_d = (st_q == RUN) && (st_d != RUN);
    assign stat_d = (stat_q & ~irq_clr_i[c]) | irq_d;
    assign sr_x = {sr_q, req_o[c]};
    assign sr_d = sr_x[ACK_LAT-1:0];
    assign stat_d_v[c] = stat_d;
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= IDLE;
        cnt_q <= '0;
        sr_q <= '0;
        irq_q <= 1'b0;
        stat_q <= 1'b0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
        sr_q <= sr_d;
        irq_q <= irq_d;
        stat_q <= stat_d;
      end
    end
    assign rdy_o[c] = st_q == IDLE;
    assign busy_o[c] = st_q == RUN;
    assign endd_o[c] = st_q == DONE;
    assign stop_o[c] = st_q == STOP;
    assign er_o[c] = st_q == ERR;
    assign req_o[c] = st_q == DONE;
    assign ack_o[c] = sr_q[ACK_LAT-1];
    assign irq_o[c] = irq_q;
    assign irq_stat_o[c] = stat_q;
  end
  assign any_irq_d = |stat_d_v;
  always_ff @(posedge clk) any_irq_q <= rst ? 1'b0 : any_irq_d;
  assign any_irq_o = any_irq_q;
endmodule

// File: tb/tb_multi_chan_seq_ctrl.sv
// tb_multi_chan_seq_ctrl: directed self-checking bench for multi_chan_seq_ctrl
module tb_multi_chan_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] start_i, stop_i, err_i, irq_clr_i;
  logic [3:0] rdy_o, busy_o, endd_o, stop_o, er_o, req_o, ack_o, irq_o, irq_stat_o;
  logic any_irq_o;
  logic [3:0] rdy2, busy2, endd2, stop2, er2, req2, ack2, irq2, stat2;
  logic any2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  multi_chan_seq_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .err_i(err_i),
    .irq_clr_i(irq_clr_i), .rdy_o(rdy_o), .busy_o(busy_o), .endd_o(endd_o),
    .stop_o(stop_o), .er_o(er_o), .req_o(req_o), .ack_o(ack_o), .irq_o(irq_o),
    .irq_stat_o(irq_stat_o), .any_irq_o(any_irq_o)
  );
  multi_chan_seq_ctrl #(.ACK_LAT(12)) dut12 (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .err_i(err_i),
    .irq_clr_i(irq_clr_i), .rdy_o(rdy2), .busy_o(busy2), .endd_o(endd2),
    .stop_o(stop2), .er_o(er2), .req_o(req2), .ack_o(ack2), .irq_o(irq2),
    .irq_stat_o(stat2), .any_irq_o(any2)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    start_i = '0;
    stop_i = '0;
    err_i = '0;
    irq_clr_i = '0;
    tick(1);
    chk("rst_rdy", rdy_o, 4'hF);
    chk("rst_busy", busy_o, 4'h0);
    chk("rst_er", er_o, 4'h0);
    chk("rst_ack", ack_o, 4'h0);
    chk("rst_stat", {any_irq_o, irq_stat_o}, 5'h00);
    tick(1);
    rst = 1'b0;
    tick(2);
    start_i = 4'h1;
    tick(1);
    start_i = 4'h0;
    chk("t1_busy_first", busy_o, 4'h1);
    chk("t1_rdy_first", rdy_o, 4'hE);
    tick(7);
    chk("t1_busy_last", busy_o, 4'h1);
    tick(1);
    chk("t1_endd", endd_o, 4'h1);
    chk("t1_req", req_o, 4'h1);
    chk("t1_irq", irq_o, 4'h1);
    chk("t1_busy_done", busy_o, 4'h0);
    chk("t1_rdy_done", rdy_o, 4'hE);
    chk("t1_stat", {any_irq_o, irq_stat_o}, 5'h11);
    tick(1);
    chk("t1_endd_once", endd_o, 4'h0);
    chk("t1_irq_once", irq_o, 4'h0);
    chk("t1_hold1", rdy_o, 4'hE);
    tick(1);
    chk("t1_hold2", rdy_o, 4'hE);
    tick(1);
    chk("t1_idle", rdy_o, 4'hF);
    tick(1);
    chk("t1_ack_early", ack_o, 4'h0);
    tick(1);
    chk("t1_ack", ack_o, 4'h1);
    tick(1);
    chk("t1_ack_once", ack_o, 4'h0);
    chk("t1_stat_sticky", {any_irq_o, irq_stat_o}, 5'h11);
    irq_clr_i = 4'h1;
    tick(1);
    irq_clr_i = 4'h0;
    chk("t1_stat_clr", {any_irq_o, irq_stat_o}, 5'h00);
    tick(12);
    start_i = 4'h2;
    tick(1);
    start_i = 4'h0;
    tick(2);
    stop_i = 4'h2;
    tick(1);
    stop_i = 4'h0;
    chk("t2_stop", stop_o, 4'h2);
    chk("t2_endd", endd_o, 4'h0);
    chk("t2_irq", irq_o, 4'h2);
    chk("t2_busy", busy_o, 4'h0);
    tick(1);
    chk("t2_stop_once", stop_o, 4'h0);
    chk("t2_hold1", rdy_o, 4'hD);
    start_i = 4'h2;
    tick(1);
    start_i = 4'h0;
    chk("t2_hold2", rdy_o, 4'hD);
    tick(1);
    chk("t2_idle", rdy_o, 4'hF);
    chk("t2_start_ignored", busy_o, 4'h0);
    for (int i = 0; i < 8; i++) begin
      chk("t2_no_ack", {ack_o, req_o}, 8'h00);
      tick(1);
    end
    irq_clr_i = 4'hF;
    tick(1);
    irq_clr_i = 4'h0;
    start_i = 4'h4;
    tick(1);
    start_i = 4'h0;
    err_i = 4'h4;
    stop_i = 4'h4;
    tick(1);
    stop_i = 4'h0;
    chk("t3_er1", er_o, 4'h4);
    chk("t3_stop_lose", stop_o, 4'h0);
    chk("t3_irq", irq_o, 4'h4);
    tick(1);
    chk("t3_er2", er_o, 4'h4);
    chk("t3_irq_once", irq_o, 4'h0);
    tick(1);
    chk("t3_er3", er_o, 4'h4);
    tick(1);
    chk("t3_er_max", er_o, 4'h0);
    chk("t3_hold1", rdy_o, 4'hB);
    tick(1);
    chk("t3_hold2", {er_o, rdy_o}, 8'h0B);
    tick(1);
    err_i = 4'h0;
    chk("t3_idle", {er_o, busy_o, rdy_o}, 12'h00F);
    irq_clr_i = 4'hF;
    tick(1);
    irq_clr_i = 4'h0;
    tick(14);
    start_i = 4'h8;
    tick(1);
    tick(8);
    chk("t4_req1", req_o, 4'h8);
    chk("t4_stat1", irq_stat_o, 4'h8);
    irq_clr_i = 4'h8;
    tick(1);
    irq_clr_i = 4'h0;
    chk("t4_stat_clr", irq_stat_o, 4'h0);
    tick(3);
    start_i = 4'h0;
    chk("t4_busy2", busy_o, 4'h8);
    tick(1);
    chk("t4_ack5_1", ack_o, 4'h8);
    tick(6);
    chk("t4_ack12_early", ack2, 4'h0);
    irq_clr_i = 4'h8;
    tick(1);
    irq_clr_i = 4'h0;
    chk("t4_req2", req_o, 4'h8);
    chk("t4_ack12_1", ack2, 4'h8);
    chk("t4_set_wins", {any_irq_o, irq_stat_o}, 5'h18);
    tick(1);
    chk("t4_stat_hold", irq_stat_o, 4'h8);
    chk("t4_ack12_once", ack2, 4'h0);
    tick(4);
    chk("t4_ack5_2", ack_o, 4'h8);
    tick(6);
    chk("t4_ack12_2pre", ack2, 4'h0);
    tick(1);
    chk("t4_ack12_2", ack2, 4'h8);
    irq_clr_i = 4'hF;
    tick(1);
    irq_clr_i = 4'h0;
    tick(2);
    start_i = 4'hF;
    tick(1);
    start_i = 4'h0;
    tick(8);
    chk("t5_req_all", req_o, 4'hF);
    tick(3);
    start_i = 4'hF;
    tick(1);
    start_i = 4'h0;
    chk("t5_busy", busy_o, 4'hF);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_rdy", rdy_o, 4'hF);
    chk("t5_zero", {busy_o, er_o}, 8'h00);
    chk("t5_ack", ack_o, 4'h0);
    chk("t5_stat", {any_irq_o, irq_stat_o}, 5'h00);
    for (int i = 0; i < 14; i++) begin
      chk("t5_no_late", {ack2, ack_o | endd_o | stop_o | irq_o}, 8'h00);
      tick(1);
    end
    start_i = 4'hF;
    tick(1);
    start_i = 4'h0;
    err_i = 4'h2;
    tick(1);
    err_i = 4'h0;
    chk("t6_er", er_o, 4'h2);
    chk("t6_busy", busy_o, 4'hD);
    chk("t6_irq1", irq_o, 4'h2);
    tick(1);
    chk("t6_er_exit", er_o, 4'h0);
    chk("t6_ch1_hold", rdy_o[1], 1'b0);
    tick(6);
    chk("t6_endd", endd_o, 4'hD);
    chk("t6_irq", irq_o, 4'hD);
    chk("t6_stat", {any_irq_o, irq_stat_o}, 5'h1F);
    irq_clr_i = 4'h1;
    tick(1);
    chk("t6_clr0", {any_irq_o, irq_stat_o}, 5'h1E);
    irq_clr_i = 4'h2;
    tick(1);
    chk("t6_clr1", {any_irq_o, irq_stat_o}, 5'h1C);
    irq_clr_i = 4'h4;
    tick(1);
    chk("t6_clr2", {any_irq_o, irq_stat_o}, 5'h18);
    irq_clr_i = 4'h8;
    tick(1);
    irq_clr_i = 4'h0;
    chk("t6_clr3", {any_irq_o, irq_stat_o}, 5'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_chan_seq_ctrl.md
Name: multi_chan_seq_ctrl

Overview:
NUM_CH independent job-sequencer channels, each with its own state machine: start, run, end, stop and error handling.
- Per channel: ready/done/stop/error status, bounded error pulse length, post-event hold-off, fixed-latency req/ack completion handshake, sticky interrupt status.
- Generalised successor of the single-channel sequencer; sits between the job dispatcher and the interrupt controller.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
JOB_LEN, 8, RUN-state duration in cycles (>=1)
HOLDOFF, 2, cycles rdy stays low after DONE/STOP/ERR (>=1)
ERR_MAX, 3, max consecutive cycles er_o may stay high per error event (>=1)
ACK_LAT, 5, cycles from req_o pulse to ack_o pulse (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
start_i  in  NUM_CH  per-channel job start request
stop_i  in  NUM_CH  per-channel abort request
err_i  in  NUM_CH  per-channel error indication
irq_clr_i  in  NUM_CH  clear sticky interrupt status
rdy_o  out  NUM_CH  channel idle, accepts start
busy_o  out  NUM_CH  channel in RUN
endd_o  out  NUM_CH  one-cycle normal-completion pulse
stop_o  out  NUM_CH  one-cycle abort pulse
er_o  out  NUM_CH  error active
req_o  out  NUM_CH  completion request pulse (equals endd_o)
ack_o  out  NUM_CH  completion acknowledge pulse
irq_o  out  NUM_CH  one-cycle interrupt event pulse
irq_stat_o  out  NUM_CH  sticky interrupt status
any_irq_o  out  1  OR-reduction of irq_stat_o

Behaviour:
- Reset: all channels go to IDLE on the first edge with rst=1. Counters, ACK delay lines and irq_stat are cleared.
  - Reset output values: rdy_o all 1; every other output 0.
  - Reset mid-operation aborts without generating endd/stop/irq pulses.
- Per-channel FSM states: IDLE, RUN, DONE, STOP, ERR, HOLD.
- All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE: rdy_o=1.
  - start_i=1 -> RUN; run counter loads JOB_LEN-1.
  - stop_i/err_i in IDLE are ignored.
- RUN: busy_o=1, rdy_o=0. Priority each cycle is err_i > stop_i > counter.
  - err_i=1 -> ERR.
  - else stop_i=1 -> STOP.
  - else counter==0 -> DONE.
  - else counter decrements.
  - start_i is ignored while not IDLE.
- Timing for start sampled at edge t: RUN occupies t+1..t+JOB_LEN, DONE at t+JOB_LEN+1.
- DONE: endd_o=1 and req_o=1 for exactly one cycle -> HOLD.
- STOP: stop_o=1 for one cycle -> HOLD.
- ERR: er_o=1 on entry cycle; stays in ERR while err_i=1.
  - Exits to HOLD when err_i=0, or after ERR_MAX cycles in ERR regardless of err_i.
  - er_o is never high more than ERR_MAX consecutive cycles.
  - After forced exit, a still-high err_i is ignored until the next RUN.
- HOLD: rdy_o=0 for exactly HOLDOFF cycles -> IDLE.
  - rdy_o is therefore 0 the cycle after any endd/stop/er.
- Mutual exclusion per channel: rdy_o, busy_o, endd_o, stop_o, er_o are one-hot-or-zero; exactly one of rdy/busy/endd/stop/er/HOLD is active.
- ACK path: per-channel ACK_LAT-deep shift register fed by req_o; ack_o = req_o delayed exactly ACK_LAT cycles.
  - The pipeline is independent of FSM state; a new job does not cancel pending acks.
  - Overlapping requests are all preserved.
  - Cleared only by rst.
- Interrupts: irq_o=1 for one cycle in the first cycle of DONE, STOP or ERR.
  - irq_stat_o bit sets on irq_o and holds until irq_clr_i.
  - Set wins over a simultaneous clear.
  - any_irq_o is registered with the same timing as irq_stat_o.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.

Test Plan:
1. Defaults, ch0 start at cycle 10 -> busy 11..18, endd/req/irq at 19, rdy=0 19..21, rdy=1 at 22, ack at 24, irq_stat[0]=1 until clear.
2. ch1 start, stop_i at RUN cycle 3 with err_i=0 -> stop_o pulse next cycle, no endd/req/ack, HOLD 2 cycles, rdy returns; start_i during HOLD ignored.
3. ch2 in RUN, err_i held high 6 cycles -> er_o high exactly 3 cycles, then HOLD, IDLE. err_i+stop_i same cycle -> ERR taken, stop_o stays 0.
4. ch3 back-to-back jobs with ACK_LAT=12 -> two req pulses, two ack pulses each exactly 12 cycles after its req. Same-cycle irq_clr_i and new irq -> irq_stat stays 1.
5. rst asserted mid-RUN on all channels with acks in flight -> next cycle rdy=all 1, busy/er/ack/irq_stat all 0, no late ack emerges.
6. All 4 channels start same cycle, err on ch1 only -> ch0/2/3 endd at t+9; ch1 er path; any_irq_o=1 until all four bits cleared.
